// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci-style recurrence sequencer:
// controller state encoding and lower bounds on the size parameters.
package fib_pkg;

  // Controller states of the sequencer.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fibState_t;

  // A run needs two seeds plus at least one generated term.
  localparam int MinDepth   = 3;
  // At least one clock per generation step.
  localparam int MinTickDiv = 1;

  // Raises a parameter to its floor so degenerate sizes cannot collapse the datapath.
  function automatic int atLeast(input int value, input int floor);
    return (value < floor) ? floor : value;
  endfunction

endpackage

// File: rtl/fib_tick_gen.sv
// Step-rate divider for the sequencer: while Clear is low, Step pulses for
// one cycle out of every TICK_DIV. Clear holds the divider at phase 0, so the
// first Step after Clear falls arrives TICK_DIV cycles later.
module fib_tick_gen #(
  parameter int TICK_DIV = 6
) (
  input  logic Clock,
  input  logic Reset,
  input  logic Clear,
  output logic Step
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LastTick = CW'(TICK_DIV - 1);

  logic [CW-1:0] tick;

  // Phase counter: 0..TICK_DIV-1, parked at 0 while cleared.
  always_ff @(posedge Clock) begin
    if (Reset || Clear) begin
      tick <= '0;
    end else if (tick == LastTick) begin
      tick <= '0;
    end else begin
      tick <= tick + CW'(1);
    end
  end

  assign Step = !Clear && (tick == LastTick);

endmodule

// File: rtl/fib_sequencer.sv
// Recurrence sequencer: term[i] = term[i-1] + term[i-2], seeded through
// LoadA/LoadB, generated one term per TICK_DIV clocks into a DEPTH-entry
// buffer that is readable at any time through a registered read port.
//
// Build option: define FIB_OVF_STOP_EN to end a run on the first step whose
// sum carries out of WIDTH bits (the failing term is not stored). Without it
// the sum wraps, is stored, and the run continues with Overflow held sticky.
//
// Handshake: Start is a request honoured only while Busy is low (IDLE or
// DONE); the accepting edge raises Busy. Busy stays high for the whole run
// and falls on the same edge that raises Done, which is high for exactly one
// cycle. Loads and Start presented while Busy is high are dropped silently.
module fib_sequencer import fib_pkg::*; #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 6,
  localparam int AW      = $clog2(atLeast(DEPTH, MinDepth))
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             LoadA,
  input  logic             LoadB,
  input  logic [WIDTH-1:0] Seed,
  input  logic             Start,
  input  logic [AW-1:0]    ReadAddr,
  output logic [WIDTH-1:0] ReadData,
  output logic [WIDTH-1:0] Term,
  output logic [AW:0]      Count,
  output logic             Busy,
  output logic             Done,
  output logic             Overflow
);

  localparam int DepthEff   = atLeast(DEPTH, MinDepth);
  localparam int TickDivEff = atLeast(TICK_DIV, MinTickDiv);
  localparam logic [AW:0] LastIdx  = (AW+1)'(DepthEff - 1);
  localparam logic [AW:0] DepthCnt = (AW+1)'(DepthEff);

  fibState_t        state;
  logic [WIDTH-1:0] termMem [DepthEff];

  logic             step;
  logic             tickClear;
  logic [AW-1:0]    wrIdx;
  logic [AW-1:0]    prevIdx1;
  logic [AW-1:0]    prevIdx2;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] sumBits;
  logic             carry;
  logic             stopOnOvf;
  logic             lastStep;

  // The divider only runs in RUN; any other state parks it at phase 0.
  assign tickClear = (state != RUN);

  fib_tick_gen #(
    .TICK_DIV(TickDivEff)
  ) uTickGen (
    .Clock(Clock),
    .Reset(Reset),
    .Clear(tickClear),
    .Step (step)
  );

  // Count always points at the next free slot during a run (2..DEPTH-1).
  assign wrIdx    = Count[AW-1:0];
  assign prevIdx1 = wrIdx - AW'(1);
  assign prevIdx2 = wrIdx - AW'(2);
  assign sum      = {1'b0, termMem[prevIdx1]} + {1'b0, termMem[prevIdx2]};
  assign sumBits  = sum[WIDTH-1:0];
  assign carry    = sum[WIDTH];
  assign lastStep = (Count == LastIdx);

`ifdef FIB_OVF_STOP_EN
  assign stopOnOvf = carry;
`else
  assign stopOnOvf = 1'b0;
`endif

  // Controller: run sequencing plus the registered status outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      Term     <= '0;
      Count    <= '0;
      Busy     <= 1'b0;
      Done     <= 1'b0;
      Overflow <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (Start) begin
            state    <= RUN;
            Count    <= (AW+1)'(2);
            Overflow <= 1'b0;
            Busy     <= 1'b1;
          end
        end
        RUN: begin
          if (step) begin
            Term <= sumBits;
            if (carry) begin
              Overflow <= 1'b1;
            end
            if (stopOnOvf) begin
              // Failing step: Count stays on the slot that was not written.
              state <= DONE;
              Busy  <= 1'b0;
              Done  <= 1'b1;
            end else begin
              Count <= Count + (AW+1)'(1);
              if (lastStep) begin
                state <= DONE;
                Busy  <= 1'b0;
                Done  <= 1'b1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

  // Term buffer writes: seeds outside a run, generated terms during it. Not reset.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      if (state != RUN) begin
        if (LoadA) begin
          termMem[0] <= Seed;
        end
        if (LoadB) begin
          termMem[1] <= Seed;
        end
      end else if (step && !stopOnOvf) begin
        termMem[wrIdx] <= sumBits;
      end
    end
  end

  // Registered read port; a same-edge write is not forwarded, addresses past the end read 0.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      ReadData <= '0;
    end else if ({1'b0, ReadAddr} < DepthCnt) begin
      ReadData <= termMem[ReadAddr];
    end else begin
      ReadData <= '0;
    end
  end

endmodule

// File: tb/tb_fib_sequencer.sv
// Bench for fib_sequencer built as WIDTH=8, DEPTH=12, TICK_DIV=2 so that
// both clean and wrapping runs fit into short directed vectors.
module tb_fib_sequencer;

  localparam int Width   = 8;
  localparam int Depth   = 12;
  localparam int TickDiv = 2;
  localparam int Aw      = $clog2(Depth);

`ifdef FIB_OVF_STOP_EN
  localparam bit StopEn = 1'b1;
`else
  localparam bit StopEn = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             Clock = 1'b0;
  logic             Reset;
  logic             LoadA;
  logic             LoadB;
  logic [Width-1:0] Seed;
  logic             Start;
  logic [Aw-1:0]    ReadAddr;
  logic [Width-1:0] ReadData;
  logic [Width-1:0] Term;
  logic [Aw:0]      Count;
  logic             Busy;
  logic             Done;
  logic             Overflow;

  always #5 Clock = ~Clock;

  fib_sequencer #(
    .WIDTH   (Width),
    .DEPTH   (Depth),
    .TICK_DIV(TickDiv)
  ) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .LoadA   (LoadA),
    .LoadB   (LoadB),
    .Seed    (Seed),
    .Start   (Start),
    .ReadAddr(ReadAddr),
    .ReadData(ReadData),
    .Term    (Term),
    .Count   (Count),
    .Busy    (Busy),
    .Done    (Done),
    .Overflow(Overflow)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;

  logic [Width-1:0]      readExp [$];
  logic [Width+Aw+1:0]   runExp  [$];   // {term, count, overflow}
  logic [Width+Aw+1:0]   runPop;
  logic                  rdReq   = 1'b0;
  logic                  rdValid = 1'b0;

  // Hand-computed buffer for seeds 0/1 (no carry within 12 terms).
  logic [Width-1:0] seqA [Depth] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5,
                                     8'd8, 8'd13, 8'd21, 8'd34, 8'd55, 8'd89};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  always @(posedge Clock) rdValid <= rdReq;

  always @(negedge Clock) begin
    if (rdValid) begin
      if (readExp.size() == 0) begin
        check("read_underflow", readExp.size(), 1);
      end else begin
        check("read_data", ReadData, readExp.pop_front());
      end
    end
    if (Done) begin
      check("done_busy_low", Busy, 0);
      if (runExp.size() == 0) begin
        check("done_unexpected", runExp.size(), 1);
      end else begin
        runPop = runExp.pop_front();
        check("done_term",     Term,     runPop[Width+Aw+1 -: Width]);
        check("done_count",    Count,    runPop[Aw+1 -: Aw+1]);
        check("done_overflow", Overflow, runPop[0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick1();
    @(posedge Clock);
    #1;
  endtask

  task automatic loadSeeds(input logic [Width-1:0] a, input logic [Width-1:0] b);
    Seed = a; LoadA = 1'b1;
    tick1();
    LoadA = 1'b0; Seed = b; LoadB = 1'b1;
    tick1();
    LoadB = 1'b0;
  endtask

  task automatic startRun();
    Start = 1'b1;
    tick1();
    Start = 1'b0;
  endtask

  task automatic pushRun(input logic [Width-1:0] t, input logic [Aw:0] c, input logic o);
    runExp.push_back({t, c, o});
  endtask

  task automatic doRead(input logic [Aw-1:0] a, input logic [Width-1:0] exp);
    ReadAddr = a;
    rdReq    = 1'b1;
    readExp.push_back(exp);
    tick1();
    rdReq    = 1'b0;
  endtask

  // Counts negedges after the Start-accepting edge until Done; lastSeen is the
  // index of the last negedge already consumed by the caller (-1 for none).
  task automatic waitDone(input int lastSeen, output int doneAt, output int busyN);
    int n;
    n      = lastSeen;
    busyN  = 0;
    doneAt = -1;
    for (int k = 0; k < 400; k++) begin
      @(negedge Clock);
      n++;
      if (Done) begin
        doneAt = n;
        break;
      end
      if (Busy) busyN++;
    end
    if (doneAt < 0) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no Done within 400 cycles");
    end
    @(negedge Clock);
    check("done_one_cycle", Done, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int doneAt;
    int busyN;
    int expDone;

    Reset = 1'b1; LoadA = 1'b0; LoadB = 1'b0; Start = 1'b0;
    Seed = '0; ReadAddr = '0;
    repeat (3) @(posedge Clock);
    @(negedge Clock);
    check("rst_busy",     Busy,     0);
    check("rst_done",     Done,     0);
    check("rst_count",    Count,    0);
    check("rst_term",     Term,     0);
    check("rst_overflow", Overflow, 0);
    check("rst_readdata", ReadData, 0);
    tick1();
    Reset = 1'b0;

    // Seeds 0/1: step timing and a clean full run.
    loadSeeds(8'd0, 8'd1);
    pushRun(8'd89, 5'd12, 1'b0);
    startRun();
    @(negedge Clock);
    check("start_busy",  Busy,  1);
    check("start_count", Count, 2);
    check("start_term",  Term,  0);
    @(negedge Clock);
    check("term_before_step1", Term, 0);
    @(negedge Clock);
    check("step1_term",  Term,  1);
    check("step1_count", Count, 3);
    @(negedge Clock);
    check("step1_hold",  Term,  1);
    @(negedge Clock);
    check("step2_term",  Term,  2);
    check("step2_count", Count, 4);
    waitDone(4, doneAt, busyN);
    check("r1_done_at", doneAt, 20);
    check("r1_busy_cycles", busyN, 15);
    for (int a = 0; a < Depth; a++) doRead(Aw'(a), seqA[a]);
    doRead(4'd12, 8'd0);
    doRead(4'd15, 8'd0);

    // Loads and Start while busy are ignored.
    pushRun(8'd89, 5'd12, 1'b0);
    startRun();
    repeat (3) tick1();
    Seed = 8'd7; LoadA = 1'b1; Start = 1'b1;
    tick1();
    LoadA = 1'b0; Start = 1'b0; Seed = '0;
    waitDone(3, doneAt, busyN);
    check("busy_ignore_done_at", doneAt, 20);
    doRead(4'd0, 8'd0);
    doRead(4'd1, 8'd1);
    doRead(4'd11, 8'd89);

    // Reset as the 5th step lands, then rerun with the kept seeds.
    startRun();
    repeat (9) tick1();
    check("pre_rst_count", Count, 6);
    check("pre_rst_term",  Term,  5);
    Reset = 1'b1;
    tick1();
    check("mid_rst_busy",     Busy,     0);
    check("mid_rst_count",    Count,    0);
    check("mid_rst_term",     Term,     0);
    check("mid_rst_overflow", Overflow, 0);
    check("mid_rst_readdata", ReadData, 0);
    Reset = 1'b0;
    tick1();
    pushRun(8'd89, 5'd12, 1'b0);
    startRun();
    waitDone(-1, doneAt, busyN);
    check("rerun_done_at", doneAt, 20);
    check("rerun_busy_cycles", busyN, 20);
    for (int a = 0; a < Depth; a++) doRead(Aw'(a), seqA[a]);

    // Both loads and Start in one cycle: seeds 3/3, carry on term[10].
    Seed = 8'd3; LoadA = 1'b1; LoadB = 1'b1; Start = 1'b1;
    if (StopEn) pushRun(8'd11, 5'd10, 1'b1);
    else        pushRun(8'd176, 5'd12, 1'b1);
    tick1();
    LoadA = 1'b0; LoadB = 1'b0; Start = 1'b0; Seed = '0;
    expDone = StopEn ? 18 : 20;
    waitDone(-1, doneAt, busyN);
    check("s33_done_at", doneAt, expDone);
    check("s33_busy_cycles", busyN, expDone);
    doRead(4'd2, 8'd6);
    doRead(4'd10, StopEn ? 8'd55 : 8'd11);
    doRead(4'd11, StopEn ? 8'd89 : 8'd176);

    // Seeds 5/200: carry already on term[3].
    loadSeeds(8'd5, 8'd200);
    if (StopEn) pushRun(8'd149, 5'd3, 1'b1);
    else        pushRun(8'd155, 5'd12, 1'b1);
    startRun();
    expDone = StopEn ? 4 : 20;
    waitDone(-1, doneAt, busyN);
    check("s5_200_done_at", doneAt, expDone);
    check("s5_200_busy_after", Busy, 0);
    doRead(4'd2, 8'd205);
    doRead(4'd3, StopEn ? 8'd9 : 8'd149);

    // Start from DONE clears the sticky Overflow.
    if (StopEn) pushRun(8'd149, 5'd3, 1'b1);
    else        pushRun(8'd155, 5'd12, 1'b1);
    startRun();
    @(negedge Clock);
    check("restart_overflow_clear", Overflow, 0);
    check("restart_count", Count, 2);
    check("restart_busy",  Busy,  1);
    waitDone(0, doneAt, busyN);
    check("restart_done_at", doneAt, expDone);

    repeat (3) tick1();
    check("read_queue_drained", readExp.size(), 0);
    check("run_queue_drained",  runExp.size(),  0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
